// File: rtl/registrador_ataque_if.sv
// Player-side bundle of the attack register: switch/button inputs, matrix and status outputs.
// Pure wiring; no latency and no backpressure.
interface registrador_ataque_if;
    logic [2:0]  linha;
    logic [2:0]  coluna;
    logic        botao;
    logic        novo_jogo;
    logic [34:0] pos_mat;
    logic [34:0] atq_mat;
    logic [34:0] acerto_mat;
    logic        verde;
    logic        vermelho;
    logic        invalido;
    logic [5:0]  tiros;
    logic [5:0]  acertos;
    logic        vitoria;
    logic        derrota;
    logic        ocupado;

    modport master (
        output linha, coluna, botao, novo_jogo, pos_mat,
        input  atq_mat, acerto_mat, verde, vermelho, invalido,
        input  tiros, acertos, vitoria, derrota, ocupado
    );

    modport slave (
        input  linha, coluna, botao, novo_jogo, pos_mat,
        output atq_mat, acerto_mat, verde, vermelho, invalido,
        output tiros, acertos, vitoria, derrota, ocupado
    );
endinterface

// File: rtl/registrador_ataque.sv
// Battleship attack front end: synchronised fire button -> validated shot -> matrices, counters, LEDs.
// Press to update in 5 cycles (4 for a rejected shot); presses outside IDLE are dropped, never queued.
module registrador_ataque #(
    parameter int SHOW_CYCLES = 50_000_000,
    parameter int MAX_TIROS   = 20
) (
    input  logic clk,
    input  logic rst_n,
    registrador_ataque_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CHECK, UPDATE, SHOW, DONE} state_t;

    localparam logic [25:0] SHOW_LOAD = 26'(SHOW_CYCLES - 1);
    localparam logic [5:0]  TIROS_MAX = 6'(MAX_TIROS);

    state_t      state_q, state_d;
    logic [2:0]  sync_q;
    logic        disparo_q;
    logic [2:0]  linha_q, linha_d;
    logic [2:0]  coluna_q, coluna_d;
    logic [34:0] atq_q, atq_d;
    logic [34:0] acerto_q, acerto_d;
    logic [5:0]  tiros_q, tiros_d;
    logic [5:0]  acertos_q, acertos_d;
    logic        verde_q, verde_d;
    logic        vermelho_q, vermelho_d;
    logic        invalido_q, invalido_d;
    logic        vitoria_q, vitoria_d;
    logic        derrota_q, derrota_d;
    logic        ocupado_q, ocupado_d;
    logic [25:0] cnt_q, cnt_d;

    logic [5:0]  idx;
    logic [34:0] mask;
    logic        in_range;
    logic        ja_atirado;
    logic        acerto_pos;
    logic        victory;
    logic        defeat;

    always_comb begin
        idx        = {3'b000, linha_q} * 6'd5 + {3'b000, coluna_q};
        mask       = 35'd1 << idx;
        in_range   = (linha_q <= 3'd6) && (coluna_q <= 3'd4);
        ja_atirado = |(atq_q & mask);
        acerto_pos = |(bus.pos_mat & mask);
        // An empty fleet can never be sunk, so it can only end in defeat.
        victory    = (bus.pos_mat != 35'd0) && ((bus.pos_mat & ~acerto_q) == 35'd0);
        defeat     = (tiros_q == TIROS_MAX) && !victory;
    end

    always_comb begin
        state_d    = state_q;
        linha_d    = linha_q;
        coluna_d   = coluna_q;
        atq_d      = atq_q;
        acerto_d   = acerto_q;
        tiros_d    = tiros_q;
        acertos_d  = acertos_q;
        verde_d    = verde_q;
        vermelho_d = vermelho_q;
        invalido_d = invalido_q;
        vitoria_d  = vitoria_q;
        derrota_d  = derrota_q;
        cnt_d      = cnt_q;

        case (state_q)
            IDLE: begin
                if (disparo_q) begin
                    linha_d  = bus.linha;
                    coluna_d = bus.coluna;
                    state_d  = CHECK;
                end
            end
            CHECK: begin
                if (!in_range || ja_atirado) begin
                    invalido_d = 1'b1;
                    cnt_d      = SHOW_LOAD;
                    state_d    = SHOW;
                end else begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                atq_d   = atq_q | mask;
                tiros_d = tiros_q + 6'd1;
                if (acerto_pos) begin
                    acerto_d  = acerto_q | mask;
                    acertos_d = acertos_q + 6'd1;
                    verde_d   = 1'b1;
                end else begin
                    vermelho_d = 1'b1;
                end
                cnt_d   = SHOW_LOAD;
                state_d = SHOW;
            end
            SHOW: begin
                if (cnt_q == 26'd0) begin
                    verde_d    = 1'b0;
                    vermelho_d = 1'b0;
                    invalido_d = 1'b0;
                    if (victory) begin
                        vitoria_d = 1'b1;
                        state_d   = DONE;
                    end else if (defeat) begin
                        derrota_d = 1'b1;
                        state_d   = DONE;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 26'd1;
                end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase

        if (bus.novo_jogo) begin
            state_d    = IDLE;
            atq_d      = 35'd0;
            acerto_d   = 35'd0;
            tiros_d    = 6'd0;
            acertos_d  = 6'd0;
            verde_d    = 1'b0;
            vermelho_d = 1'b0;
            invalido_d = 1'b0;
            vitoria_d  = 1'b0;
            derrota_d  = 1'b0;
            cnt_d      = 26'd0;
        end

        ocupado_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sync_q     <= 3'b000;
            disparo_q  <= 1'b0;
            linha_q    <= 3'd0;
            coluna_q   <= 3'd0;
            atq_q      <= 35'd0;
            acerto_q   <= 35'd0;
            tiros_q    <= 6'd0;
            acertos_q  <= 6'd0;
            verde_q    <= 1'b0;
            vermelho_q <= 1'b0;
            invalido_q <= 1'b0;
            vitoria_q  <= 1'b0;
            derrota_q  <= 1'b0;
            ocupado_q  <= 1'b0;
            cnt_q      <= 26'd0;
        end else begin
            // sync_q[1:0] is the metastability pair; sync_q[2] is the edge-detect history.
            sync_q     <= {sync_q[1:0], bus.botao};
            disparo_q  <= sync_q[1] & ~sync_q[2];
            state_q    <= state_d;
            linha_q    <= linha_d;
            coluna_q   <= coluna_d;
            atq_q      <= atq_d;
            acerto_q   <= acerto_d;
            tiros_q    <= tiros_d;
            acertos_q  <= acertos_d;
            verde_q    <= verde_d;
            vermelho_q <= vermelho_d;
            invalido_q <= invalido_d;
            vitoria_q  <= vitoria_d;
            derrota_q  <= derrota_d;
            ocupado_q  <= ocupado_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.atq_mat    = atq_q;
    assign bus.acerto_mat = acerto_q;
    assign bus.verde      = verde_q;
    assign bus.vermelho   = vermelho_q;
    assign bus.invalido   = invalido_q;
    assign bus.tiros      = tiros_q;
    assign bus.acertos    = acertos_q;
    assign bus.vitoria    = vitoria_q;
    assign bus.derrota    = derrota_q;
    assign bus.ocupado    = ocupado_q;
endmodule

// File: tb/tb_registrador_ataque.sv
// Directed bench for registrador_ataque: shot table plus timing, drop, hold and reset sequences.
module tb_registrador_ataque;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    registrador_ataque_if bus();

    registrador_ataque #(.SHOW_CYCLES(4), .MAX_TIROS(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          clr;
        logic [34:0] pos;
        logic [2:0]  l;
        logic [2:0]  c;
        logic [2:0]  ind;
        logic [34:0] atq;
        logic [34:0] acr;
        logic [5:0]  tir;
        logic [5:0]  acs;
        logic        vit;
        logic        der;
    } vec_t;

    localparam logic [34:0] B0  = 35'd1;
    localparam logic [34:0] B7  = 35'd1 << 7;
    localparam logic [34:0] B34 = 35'd1 << 34;

    vec_t vt[13];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic novo_jogo_pulse();
        bus.novo_jogo = 1'b1;
        tick(1);
        bus.novo_jogo = 1'b0;
        tick(1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".atq"},    64'(bus.atq_mat), 64'd0);
        check({tag, ".acerto"}, 64'(bus.acerto_mat), 64'd0);
        check({tag, ".tiros"},  64'(bus.tiros), 64'd0);
        check({tag, ".acertos"},64'(bus.acertos), 64'd0);
        check({tag, ".ind"},    64'({bus.verde, bus.vermelho, bus.invalido}), 64'd0);
        check({tag, ".fim"},    64'({bus.vitoria, bus.derrota}), 64'd0);
        check({tag, ".ocupado"},64'(bus.ocupado), 64'd0);
    endtask

    initial begin
        int cnt_verde;
        int first;

        //             clr pos       l     c     ind     atq              acr        tir  acs  vit  der
        vt[0]  = '{1'b1, B7,       3'd1, 3'd2, 3'b100, B7,          B7,        6'd1, 6'd1, 1'b1, 1'b0};
        vt[1]  = '{1'b1, B34,      3'd0, 3'd0, 3'b010, B0,          35'd0,     6'd1, 6'd0, 1'b0, 1'b0};
        vt[2]  = '{1'b0, B34,      3'd0, 3'd0, 3'b001, B0,          35'd0,     6'd1, 6'd0, 1'b0, 1'b0};
        vt[3]  = '{1'b0, B34,      3'd7, 3'd0, 3'b001, B0,          35'd0,     6'd1, 6'd0, 1'b0, 1'b0};
        vt[4]  = '{1'b0, B34,      3'd0, 3'd5, 3'b001, B0,          35'd0,     6'd1, 6'd0, 1'b0, 1'b0};
        vt[5]  = '{1'b0, B34,      3'd6, 3'd4, 3'b100, B0 | B34,    B34,       6'd2, 6'd1, 1'b1, 1'b0};
        vt[6]  = '{1'b1, B0 | B34, 3'd0, 3'd0, 3'b100, B0,          B0,        6'd1, 6'd1, 1'b0, 1'b0};
        vt[7]  = '{1'b0, B0 | B34, 3'd6, 3'd4, 3'b100, B0 | B34,    B0 | B34,  6'd2, 6'd2, 1'b1, 1'b0};
        vt[8]  = '{1'b0, B0 | B34, 3'd3, 3'd3, 3'b000, B0 | B34,    B0 | B34,  6'd2, 6'd2, 1'b1, 1'b0};
        vt[9]  = '{1'b1, B34,      3'd0, 3'd0, 3'b010, B0,          35'd0,     6'd1, 6'd0, 1'b0, 1'b0};
        vt[10] = '{1'b0, B34,      3'd0, 3'd1, 3'b010, 35'd3,       35'd0,     6'd2, 6'd0, 1'b0, 1'b0};
        vt[11] = '{1'b0, B34,      3'd0, 3'd2, 3'b010, 35'd7,       35'd0,     6'd3, 6'd0, 1'b0, 1'b1};
        vt[12] = '{1'b0, B34,      3'd1, 3'd0, 3'b000, 35'd7,       35'd0,     6'd3, 6'd0, 1'b0, 1'b1};

        bus.linha = 3'd0;
        bus.coluna = 3'd0;
        bus.botao = 1'b0;
        bus.novo_jogo = 1'b0;
        bus.pos_mat = 35'd0;

        tick(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        tick(2);

        for (int i = 0; i < 13; i++) begin
            if (vt[i].clr) begin
                bus.pos_mat = vt[i].pos;
                novo_jogo_pulse();
            end
            bus.linha  = vt[i].l;
            bus.coluna = vt[i].c;
            bus.botao  = 1'b1;
            tick(6);
            check($sformatf("v%0d.ind", i),     64'({bus.verde, bus.vermelho, bus.invalido}), 64'(vt[i].ind));
            check($sformatf("v%0d.atq", i),     64'(bus.atq_mat), 64'(vt[i].atq));
            check($sformatf("v%0d.acerto", i),  64'(bus.acerto_mat), 64'(vt[i].acr));
            check($sformatf("v%0d.tiros", i),   64'(bus.tiros), 64'(vt[i].tir));
            check($sformatf("v%0d.acertos", i), 64'(bus.acertos), 64'(vt[i].acs));
            bus.botao = 1'b0;
            tick(8);
            check($sformatf("v%0d.ind_off", i), 64'({bus.verde, bus.vermelho, bus.invalido}), 64'd0);
            check($sformatf("v%0d.vitoria", i), 64'(bus.vitoria), 64'(vt[i].vit));
            check($sformatf("v%0d.derrota", i), 64'(bus.derrota), 64'(vt[i].der));
            check($sformatf("v%0d.ocupado", i), 64'(bus.ocupado), 64'(vt[i].vit | vt[i].der));
        end

        novo_jogo_pulse();
        check_all_zero("novo_jogo");

        // Exact latency and indication width.
        bus.pos_mat = B7;
        bus.linha = 3'd1;
        bus.coluna = 3'd2;
        bus.botao = 1'b1;
        tick(5);
        check("lat.tiros_k4", 64'(bus.tiros), 64'd0);
        check("lat.verde_k4", 64'(bus.verde), 64'd0);
        check("lat.ocupado_k4", 64'(bus.ocupado), 64'd1);
        cnt_verde = 0;
        first = -1;
        for (int i = 0; i < 14; i++) begin
            tick(1);
            if (bus.verde) begin
                cnt_verde++;
                if (first < 0) first = i;
            end
        end
        bus.botao = 1'b0;
        check("lat.verde_cycles", 64'(cnt_verde), 64'd4);
        check("lat.verde_first", 64'(first), 64'd0);
        check("lat.vitoria", 64'(bus.vitoria), 64'd1);
        novo_jogo_pulse();

        // Second press while the first shot is still on display is dropped.
        bus.pos_mat = B34;
        bus.linha = 3'd0;
        bus.coluna = 3'd0;
        bus.botao = 1'b1;
        tick(3);
        bus.botao = 1'b0;
        tick(2);
        bus.coluna = 3'd1;
        bus.botao = 1'b1;
        tick(2);
        bus.botao = 1'b0;
        tick(12);
        check("drop.tiros", 64'(bus.tiros), 64'd1);
        check("drop.atq", 64'(bus.atq_mat), 64'(B0));
        check("drop.ocupado", 64'(bus.ocupado), 64'd0);
        novo_jogo_pulse();

        // Long hold fires exactly once; empty fleet never wins.
        bus.pos_mat = 35'd0;
        bus.linha = 3'd2;
        bus.coluna = 3'd2;
        bus.botao = 1'b1;
        tick(100);
        bus.botao = 1'b0;
        tick(10);
        check("hold.tiros", 64'(bus.tiros), 64'd1);
        check("hold.atq", 64'(bus.atq_mat), 64'(35'd1 << 12));
        check("hold.vitoria", 64'(bus.vitoria), 64'd0);
        check("hold.ocupado", 64'(bus.ocupado), 64'd0);
        novo_jogo_pulse();

        // Asynchronous reset while UPDATE is in progress.
        bus.pos_mat = B7;
        bus.linha = 3'd1;
        bus.coluna = 3'd2;
        bus.botao = 1'b1;
        tick(5);
        check("rst.ocupado_before", 64'(bus.ocupado), 64'd1);
        check("rst.tiros_before", 64'(bus.tiros), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        bus.botao = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(12);
        check_all_zero("rst_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
